// File: rtl/ext_int_pkg.sv
// ext_int_pkg: sense-mode encodings and sizing helper shared by the
// external-interrupt controller and its per-channel front end.
package ext_int_pkg;

  // AVR-style interrupt sense control, two bits per channel.
  typedef enum logic [1:0] {
    ISC_LOW  = 2'b00,
    ISC_ANY  = 2'b01,
    ISC_FALL = 2'b10,
    ISC_RISE = 2'b11
  } isc_e;

  // Width of the channel-id output; a single channel still gets one bit.
  function automatic int unsigned id_width(input int unsigned nch);
    int unsigned w;
    w = 1;
    if (nch > 1) w = $clog2(nch);
    return w;
  endfunction

endpackage

// File: rtl/ext_int_sync_filter.sv
// ext_int_sync_filter: one channel front end. Two-flop synchroniser,
// optional glitch filter (EXT_INT_FILTER_EN) and the history register h
// used by the edge decoder in the top level.
module ext_int_sync_filter
  import ext_int_pkg::*;
#(
  parameter logic        IDLE_LEVEL = 1'b1,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_f,
  output logic o_h
);

  logic [1:0] r_sync;
  logic       r_h;
  logic       w_s;
  logic       w_f;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= {2{IDLE_LEVEL}};
    else       r_sync <= {r_sync[0], i_pin};
  end

  assign w_s = r_sync[1];

`ifdef EXT_INT_FILTER_EN
  localparam int unsigned      CNT_W   = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_f;

  // Accept a new level only after it has disagreed with f for FILTER_LEN edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_f   <= IDLE_LEVEL;
    end else if (w_s == r_f) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_f   <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_f = r_f;
`else
  assign w_f = w_s;

  // FILTER_LEN has no hardware in the unfiltered build.
  if (FILTER_LEN < 2) begin : g_filter_len_unused
  end
`endif

  // History tracks f every cycle, enabled or not, so no stale edge survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_h <= IDLE_LEVEL;
    else       r_h <= w_f;
  end

  assign o_f = w_f;
  assign o_h = r_h;

endmodule

// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: N-channel external interrupt controller. Per-channel sense
// decode, sticky flags with set-over-clear priority, and a lowest-index
// priority encoder feeding the core. Glitch filter via EXT_INT_FILTER_EN.
module ext_int_ctrl
  import ext_int_pkg::*;
#(
  parameter  int unsigned NCH        = 2,
  parameter  logic        IDLE_LEVEL = 1'b1,
  parameter  int unsigned FILTER_LEN = 4,
  localparam int unsigned ID_W       = id_width(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   pin_i,
  input  logic [NCH-1:0]   en_i,
  input  logic [2*NCH-1:0] mode_i,
  input  logic [NCH-1:0]   clr_i,
  input  logic             irq_ack_i,
  output logic [NCH-1:0]   flag_o,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o
);

  logic [NCH-1:0]  w_f;
  logic [NCH-1:0]  w_h;
  logic [NCH-1:0]  w_event;
  logic [NCH-1:0]  w_set;
  logic [NCH-1:0]  w_clr;
  logic [NCH-1:0]  w_pend;
  logic [ID_W-1:0] w_id;
  logic            w_irq;
  logic [NCH-1:0]  r_flag;

  for (genvar k = 0; k < int'(NCH); k++) begin : g_ch
    ext_int_sync_filter #(
      .IDLE_LEVEL (IDLE_LEVEL),
      .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
      .clk   (clk),
      .reset (reset),
      .i_pin (pin_i[k]),
      .o_f   (w_f[k]),
      .o_h   (w_h[k])
    );
  end

  // Decode each channel's event from its current sense mode.
  always_comb begin
    w_event = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      case (isc_e'(mode_i[2*k +: 2]))
        ISC_LOW:  w_event[k] = ~w_f[k];
        ISC_ANY:  w_event[k] = w_f[k] ^ w_h[k];
        ISC_FALL: w_event[k] = w_h[k] & ~w_f[k];
        ISC_RISE: w_event[k] = ~w_h[k] & w_f[k];
        default:  w_event[k] = 1'b0;
      endcase
    end
  end

  assign w_set  = en_i & w_event;
  assign w_pend = r_flag & en_i;
  assign w_irq  = |w_pend;

  // Lowest-numbered pending enabled channel wins; zero when nothing pends.
  always_comb begin
    w_id = '0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (w_pend[k]) w_id = ID_W'(k);
    end
  end

  // Software clear plus acknowledge of the channel currently presented.
  always_comb begin
    w_clr = clr_i;
    for (int k = 0; k < int'(NCH); k++) begin
      if (irq_ack_i && w_irq && (w_id == ID_W'(k))) w_clr[k] = 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle overrides any clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_flag <= '0;
    else       r_flag <= w_set | (r_flag & ~w_clr);
  end

  assign flag_o   = r_flag;
  assign irq_o    = w_irq;
  assign irq_id_o = w_id;

endmodule

// File: doc/ext_int_ctrl.md
# ext_int_ctrl

Parametrised external-interrupt controller for the RISC-V Arduino-compatible core. It generalises the fixed two-pin INT0/INT1 toggle detector to N channels. Each channel has an AVR-style sense mode (low level, any change, falling, rising), a sticky flag, and enable masking. The block sits between the GPIO port pins and the core's interrupt input: it presents one prioritised request (`irq_o`, `irq_id_o`) and takes an acknowledge that clears the serviced flag.

## Interface
Parameters:
- `NCH`, 2: number of interrupt channels, 1..16.
- `IDLE_LEVEL`, 1'b1: reset value of the synchroniser and history registers, so that a pin idling at this level produces no edge after reset.
- `FILTER_LEN`, 4: number of consecutive equal samples required by the glitch filter, 2..255. Used only with `EXT_INT_FILTER_EN`.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `pin_i`  in  NCH: raw asynchronous pin levels.
- `en_i`  in  NCH: per-channel enable (INTn mask).
- `mode_i`  in  2*NCH: sense mode, channel k at bits [2k+1:2k]. 00 low level, 01 any change, 10 falling, 11 rising.
- `clr_i`  in  NCH: write-one-to-clear strobe for flags, for software access through the register file.
- `irq_ack_i`  in  1: one-cycle acknowledge from the core. Clears the flag of `irq_id_o`.
- `flag_o`  out  NCH: sticky interrupt flags (INTFn).
- `irq_o`  out  1: OR over all k of `flag_o[k] & en_i[k]`.
- `irq_id_o`  out  $clog2(NCH) (min 1): lowest-numbered pending enabled channel. Reads 0 when `irq_o` is low.

## Operation
- Per channel: a 2-FF synchroniser produces `s`. An optional filter produces `f`; without the filter, `f = s`. A history register `h` loads `f` every cycle.
- Event decode from `f`/`h`:
  - any change: `f != h`
  - falling: `h & ~f`
  - rising: `~h & f`
  - low level: `~f`, evaluated every cycle
- Set condition: `en_i[k] & event`. When a channel is disabled, its `h` keeps tracking, so a later enable never fires on a stale edge.
- Flag update priority: set > clear. A flag is cleared by `clr_i[k]`, or by `irq_ack_i` with `irq_id_o == k`; a set in the same cycle wins. In low-level mode the flag therefore re-asserts for as long as the pin stays low.
- `irq_ack_i` while `irq_o` is low is ignored.
- A change on `mode_i` never alters a flag directly. Only events decoded with the new mode, from the following cycle on, set flags.
- `flag_o` is a register. `irq_o` and `irq_id_o` are combinational from `flag_o` and `en_i`.

## Timing
- Reset: `flag_o` = 0, `irq_o` = 0, `irq_id_o` = 0, synchroniser and `h` = `IDLE_LEVEL`, filter counter = 0.
- Latency without the filter: a pin level sampled at edge t is in `s` after edge t+1. The flag is high after edge t+2, and `irq_o` follows in the same cycle.
- Clear latency: a clear or ack at edge t leaves the flag low after edge t, unless a set occurs at t.
- Reset asserted mid-operation clears everything immediately and asynchronously. No event is generated on deassertion when the pins sit at `IDLE_LEVEL`.

## Configuration
- `EXT_INT_FILTER_EN` defined: each channel carries a saturating counter of `$clog2(FILTER_LEN+1)` bits.
  - The counter increments while `s != f` and resets to 0 when `s == f`.
  - When it reaches `FILTER_LEN-1` with `s != f`, `f` loads `s` and the counter returns to 0.
  - Pulses shorter than `FILTER_LEN` cycles are rejected.
  - Latency from the raw pin to the flag is 2 + `FILTER_LEN` edges.
- Not defined: `f = s`, no counter logic is generated, and `FILTER_LEN` is ignored.

## Structure
- Package `ext_int_pkg`: the mode encodings `ISC_LOW`=2'b00, `ISC_ANY`=2'b01, `ISC_FALL`=2'b10, `ISC_RISE`=2'b11, and a `function` that returns the width of `irq_id_o`.
- Sub-module `ext_int_sync_filter`: synchroniser, optional filter and `h` register for one channel, instantiated NCH times in a generate loop.
- The top level holds the flag registers and the priority encoder.

## Test plan
- Rising mode, ch0 enabled, pin 0→1 sampled at edge 10 → `flag_o[0]`=1 and `irq_o`=1 after edge 12, `irq_id_o`=0. Pin 1→0 afterwards → no new set.
- Any-change mode on ch1 with `en_i[1]`=0, toggle the pin, then enable → `flag_o[1]` stays 0. A toggle after the enable → flag set 3 edges later.
- Flags 0 and 2 pending, NCH=4 → `irq_id_o`=0. Pulse `irq_ack_i` → flag 0 cleared, `irq_id_o`=2 next cycle. Ack again → `irq_o`=0.
- Low-level mode, pin held low, `clr_i` pulsed → flag remains 1. Pin released high then `clr_i` pulsed → flag 0.
- Falling edge arriving in the same cycle as `clr_i` on that channel → flag stays 1 (set wins). Reset asserted mid-pulse → all outputs 0 at once, no flag after release with pins high.
- With `EXT_INT_FILTER_EN` and `FILTER_LEN`=4: a 3-cycle pin glitch → no flag. A 4-cycle stable change → flag after 6 edges.
